atomicity_region_mon: RTL and testbench
=======================================

# atomicity_region_mon

Parametrised successor of the single-region atomicity monitor. It watches the MSP430 program counter against up to four independent protected code regions. It enforces entry only at each region's first address and exit only from its last address. It optionally treats an interrupt taken inside a region as a violation. The block sits beside the core in the hardware-monitor group and drives the system reset request, plus a diagnostic record of the first violation and a saturating violation count.

## Interface

**Parameters**
- `NREG`, 2: number of protected regions, legal range 1..4.
- `REG_BASE`, {16'hB000, 16'hA000}: packed 16·NREG vector. Slice r is the first instruction address of region r.
- `REG_LAST`, {16'hB0FE, 16'hA0FE}: packed 16·NREG vector. Slice r is the last instruction address of region r.
- `RESET_HANDLER`, 16'hFFFE: PC value that releases the monitor from the kill state.
- `IRQ_CHECK`, 1: when 1, `irq` asserted while a region is active is a violation.
- Configuration constraints:
  - REG_BASE[r] < REG_LAST[r], both even.
  - Regions must not overlap.
  - RESET_HANDLER must lie outside all regions.

**Ports**
- `clk`  in  1  core clock. All state updates on the rising edge.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `pc`  in  16  current program counter.
- `pc_en`  in  1  pc is valid this cycle. When low, all state holds.
- `irq`  in  1  interrupt being taken this cycle.
- `reset`  out  1  system reset request, registered.
- `viol_cause`  out  3  cause of the first violation since `rst_n`. 0 means none.
- `viol_region`  out  2  region index for `viol_cause`.
- `viol_count`  out  8  number of violating cycles, saturating.

## Operation

**PC classification, per region r, combinational**
- FIRST: pc == BASE.
- LAST: pc == LAST.
- MID: BASE < pc < LAST.
- OUT: any other value.

**State machine, one per region**
- States: NOT, FST, MID, LST, KILL.
- Transitions are evaluated only when pc_en = 1.
- NOT:
  - OUT → NOT.
  - FIRST → FST.
  - MID or LAST → KILL, cause 1 (ENTRY).
- FST:
  - FIRST → FST.
  - MID → MID.
  - LAST → LST.
  - OUT → KILL, cause 2 (EXIT).
- MID:
  - MID → MID.
  - LAST → LST.
  - FIRST → KILL, cause 4 (REENTRY).
  - OUT → KILL, cause 2 (EXIT).
- LST:
  - LAST → LST.
  - OUT → NOT.
  - FIRST or MID → KILL, cause 3 (BACKJUMP).
- IRQ rule: in FST, MID or LST, if irq = 1 and IRQ_CHECK = 1, go to KILL with cause 5 (IRQ). This rule has priority over the pc rules above.
- KILL: pc == RESET_HANDLER → NOT. Otherwise stay in KILL. irq is ignored.

**Outputs**
- reset = OR over r of (state[r] == KILL).
- "Entering KILL" means state[r] ≠ KILL and next[r] == KILL.
- Violation cycle: any region enters KILL.
  - If `viol_cause` == 0, latch the cause and index of the lowest-numbered region entering KILL.
  - `viol_count` increments by 1 per violation cycle, regardless of how many regions are involved. It saturates at 8'hFF.
- `viol_cause`, `viol_region` and `viol_count` are cleared only by `rst_n`. They are not cleared by leaving KILL.

## Timing

- Asynchronous reset (`rst_n` low):
  - Every region is forced to KILL.
  - `reset` = 1.
  - `viol_cause` = 0, `viol_region` = 0, `viol_count` = 0.
- `reset` deasserts only after the first pc_en cycle with pc == RESET_HANDLER, one edge later.
- Latency:
  - A violating pc sampled at edge n gives `reset` = 1 after edge n.
  - `viol_*` update on the same edge n.
- pc_en = 0: no state change, no count change, and `reset` holds its value. This applies even if pc or irq would violate.
- Simultaneous events:
  - A jump from MID of region 0 straight to MID of region 1 is EXIT in region 0 and ENTRY in region 1.
  - Both regions go to KILL on that edge.
  - `viol_count` +1; latched record is region 0, cause 2.
- pc == RESET_HANDLER while some region is not in KILL: that region treats it as OUT.
- Count saturation: at 8'hFF, further violations leave the count at 8'hFF.
- `rst_n` asserted mid-sequence, e.g. with a region in MID: the region goes immediately to KILL and all diagnostics clear, independent of `clk`.

## Test plan

Bench configuration: NREG = 2, default regions (A000–A0FE, B000–B0FE), IRQ_CHECK = 1.

1. **Reset release.** Release `rst_n`, then drive pc = FFFE, 4000, 4002. Expect `reset` 1 → 0 one edge after FFFE. `viol_*` stay at 0.
2. **Legal pass and entry violation.** Drive pc = 4000, A000, A010, A0FE, 4100. Expect `reset` stays 0 throughout. Then drive pc = A010 directly from 4100. Expect `reset` = 1 next edge, `viol_cause` = 1, `viol_region` = 0, `viol_count` = 1.
3. **Interrupt inside region.** Drive pc = A000, A002 with irq = 1 on the A002 cycle. Expect KILL, `viol_cause` = 5. Repeat with pc_en = 0 on that cycle. Expect no violation.
4. **Back-jump.** Drive pc = A000, A0FE, A004. Expect `viol_cause` = 3. Then drive pc = FFFE. Expect `reset` = 0 next edge; `viol_cause` stays 3 and `viol_count` stays 1.
5. **Simultaneous two-region violation.** Drive pc = A000, A010, B010. Expect both regions in KILL, `viol_count` +1, `viol_region` = 0, `viol_cause` = 2.
6. **Saturation and async clear.** Force 300 violation/recovery cycles. Expect `viol_count` = FF. Pulse `rst_n` low mid-cycle. Expect immediately `reset` = 1 and all `viol_*` = 0.

Source files
------------

// File: rtl/atomicity_region_mon.sv
`default_nettype none
// ============================================================================
// atomicity_region_mon : PC atomicity monitor for up to four code regions
// Rev 1.0
// ============================================================================
module atomicity_region_mon #(
  parameter int                 NREG          = 2,
  parameter logic [16*NREG-1:0] REG_BASE      = {16'hB000, 16'hA000},
  parameter logic [16*NREG-1:0] REG_LAST      = {16'hB0FE, 16'hA0FE},
  parameter logic [15:0]        RESET_HANDLER = 16'hFFFE,
  parameter int                 IRQ_CHECK     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic        pc_en,
  input  logic        irq,
  output logic        reset,
  output logic [2:0]  viol_cause,
  output logic [1:0]  viol_region,
  output logic [7:0]  viol_count
);

  localparam logic [2:0] S_NOT  = 3'd0;
  localparam logic [2:0] S_FST  = 3'd1;
  localparam logic [2:0] S_MID  = 3'd2;
  localparam logic [2:0] S_LST  = 3'd3;
  localparam logic [2:0] S_KILL = 3'd4;

  localparam logic [2:0] C_NONE     = 3'd0;
  localparam logic [2:0] C_ENTRY    = 3'd1;
  localparam logic [2:0] C_EXIT     = 3'd2;
  localparam logic [2:0] C_BACKJUMP = 3'd3;
  localparam logic [2:0] C_REENTRY  = 3'd4;
  localparam logic [2:0] C_IRQ      = 3'd5;

  logic [NREG-1:0] kill_w;
  logic [NREG-1:0] enter_w;
  logic [2:0]      cause_w [NREG];

  for (genvar r = 0; r < NREG; r++) begin : g_region
    localparam logic [15:0] BASE = REG_BASE[16*r +: 16];
    localparam logic [15:0] LAST = REG_LAST[16*r +: 16];

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [2:0] cause_d;
    logic       is_first_w;
    logic       is_last_w;
    logic       is_mid_w;

    assign is_first_w = (pc == BASE);
    assign is_last_w  = (pc == LAST);
    assign is_mid_w   = (pc > BASE) && (pc < LAST);

    always_comb begin
      state_d = state_q;
      cause_d = C_NONE;
      if (pc_en) begin
        case (state_q)
          S_NOT: begin
            if (is_first_w) begin
              state_d = S_FST;
            end else if (is_mid_w || is_last_w) begin
              state_d = S_KILL;
              cause_d = C_ENTRY;
            end
          end
          S_FST, S_MID, S_LST: begin
            // An interrupt inside the region overrides whatever the pc says.
            if ((IRQ_CHECK != 0) && irq) begin
              state_d = S_KILL;
              cause_d = C_IRQ;
            end else if (is_last_w) begin
              state_d = S_LST;
            end else if (is_mid_w) begin
              if (state_q == S_LST) begin
                state_d = S_KILL;
                cause_d = C_BACKJUMP;
              end else begin
                state_d = S_MID;
              end
            end else if (is_first_w) begin
              if (state_q == S_FST) begin
                state_d = S_FST;
              end else begin
                state_d = S_KILL;
                cause_d = (state_q == S_MID) ? C_REENTRY : C_BACKJUMP;
              end
            end else begin
              if (state_q == S_LST) begin
                state_d = S_NOT;
              end else begin
                state_d = S_KILL;
                cause_d = C_EXIT;
              end
            end
          end
          S_KILL: begin
            if (pc == RESET_HANDLER) begin
              state_d = S_NOT;
            end
          end
          default: begin
            state_d = S_KILL;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= S_KILL;
      end else begin
        state_q <= state_d;
      end
    end

    assign kill_w[r]  = (state_q == S_KILL);
    assign enter_w[r] = (state_q != S_KILL) && (state_d == S_KILL);
    assign cause_w[r] = cause_d;
  end

  logic [2:0] first_cause_w;
  logic [1:0] first_region_w;

  // Walk downwards so the lowest-numbered entering region wins.
  always_comb begin
    first_cause_w  = C_NONE;
    first_region_w = 2'd0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (enter_w[i]) begin
        first_cause_w  = cause_w[i];
        first_region_w = 2'(i);
      end
    end
  end

  logic [2:0] cause_q;
  logic [1:0] region_q;
  logic [7:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q  <= C_NONE;
      region_q <= 2'd0;
      count_q  <= 8'd0;
    end else if (|enter_w) begin
      if (cause_q == C_NONE) begin
        cause_q  <= first_cause_w;
        region_q <= first_region_w;
      end
      if (count_q != 8'hFF) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  assign reset       = |kill_w;
  assign viol_cause  = cause_q;
  assign viol_region = region_q;
  assign viol_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_atomicity_region_mon.sv
`default_nettype none
// ============================================================================
// tb_atomicity_region_mon : directed vector bench for atomicity_region_mon
// Rev 1.0
// ============================================================================
module tb_atomicity_region_mon;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic        pc_en;
  logic        irq;
  logic        reset;
  logic [2:0]  viol_cause;
  logic [1:0]  viol_region;
  logic [7:0]  viol_count;

  int n_applied;
  int n_miscompares;

  atomicity_region_mon #(
    .NREG          (2),
    .REG_BASE      ({16'hB000, 16'hA000}),
    .REG_LAST      ({16'hB0FE, 16'hA0FE}),
    .RESET_HANDLER (16'hFFFE),
    .IRQ_CHECK     (1)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .pc_en       (pc_en),
    .irq         (irq),
    .reset       (reset),
    .viol_cause  (viol_cause),
    .viol_region (viol_region),
    .viol_count  (viol_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [15:0] pc;
    logic        en;
    logic        irq;
    logic        e_reset;
    logic [2:0]  e_cause;
    logic [1:0]  e_region;
    logic [7:0]  e_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, logic [15:0] p, logic en, logic iq,
                              logic er, logic [2:0] ec, logic [1:0] eg, logic [7:0] en_cnt);
    vec_t v;
    v.rst = rst; v.pc = p; v.en = en; v.irq = iq;
    v.e_reset = er; v.e_cause = ec; v.e_region = eg; v.e_count = en_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s [%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic er, input logic [2:0] ec,
                         input logic [1:0] eg, input logic [7:0] en_cnt);
    chk("reset",       idx, {7'd0, reset},       {7'd0, er});
    chk("viol_cause",  idx, {5'd0, viol_cause},  {5'd0, ec});
    chk("viol_region", idx, {6'd0, viol_region}, {6'd0, eg});
    chk("viol_count",  idx, viol_count,          en_cnt);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    pc_en = 1'b0; irq = 1'b0; pc = 16'h0000;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic step(input logic [15:0] p, input logic en, input logic iq);
    @(negedge clk);
    pc = p; pc_en = en; irq = iq;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_applied     = 0;
    n_miscompares = 0;
    rst_n = 1'b0; pc = 16'h0000; pc_en = 1'b0; irq = 1'b0;

    // Reset release and legal pass, then entry violation into the middle of region 0
    vecs.push_back(mk(0, 16'hFFFE, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'h4000, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'h4002, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'hA000, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'hA010, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'hA0FE, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'h4100, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'hA010, 1, 0, 1, 1, 0, 8'd1));
    vecs.push_back(mk(0, 16'hFFFE, 0, 0, 1, 1, 0, 8'd1));
    vecs.push_back(mk(0, 16'hFFFE, 1, 0, 0, 1, 0, 8'd1));
    // Interrupt inside region 0
    vecs.push_back(mk(1, 16'hFFFE, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'hA000, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'hA002, 1, 1, 1, 5, 0, 8'd1));
    // Same, but the interrupt cycle has pc_en low
    vecs.push_back(mk(1, 16'hFFFE, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'hA000, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'hA002, 0, 1, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'hA002, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'hA000, 1, 0, 1, 4, 0, 8'd1));
    // Back-jump from the last address, then recovery keeps diagnostics
    vecs.push_back(mk(1, 16'hFFFE, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'hA000, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'hA0FE, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'hA004, 1, 0, 1, 3, 0, 8'd1));
    vecs.push_back(mk(0, 16'hFFFE, 1, 0, 0, 3, 0, 8'd1));
    // Simultaneous exit of region 0 and entry into region 1
    vecs.push_back(mk(1, 16'hFFFE, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'hA000, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'hA010, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'hB010, 1, 0, 1, 2, 0, 8'd1));
    vecs.push_back(mk(0, 16'hFFFE, 1, 0, 0, 2, 0, 8'd1));
    // Entry at the last address of region 1 is recorded against region 1
    vecs.push_back(mk(1, 16'hFFFE, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 16'hB0FE, 1, 0, 1, 1, 1, 8'd1));
    vecs.push_back(mk(0, 16'hFFFE, 1, 0, 0, 1, 1, 8'd1));
    vecs.push_back(mk(0, 16'hB000, 1, 0, 0, 1, 1, 8'd1));
    vecs.push_back(mk(0, 16'hB100, 1, 0, 1, 1, 1, 8'd2));

    #12;
    rst_n = 1'b1;
    #1;
    chk_all(-1, 1'b1, 3'd0, 2'd0, 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) pulse_rst();
      step(vecs[i].pc, vecs[i].en, vecs[i].irq);
      chk_all(i, vecs[i].e_reset, vecs[i].e_cause, vecs[i].e_region, vecs[i].e_count);
    end

    // Saturation: repeated entry violation and recovery
    pulse_rst();
    step(16'hFFFE, 1'b1, 1'b0);
    for (int k = 0; k < 300; k++) begin
      step(16'hA010, 1'b1, 1'b0);
      if (k == 253) chk("count_pre_sat", k, viol_count, 8'hFE);
      if (k == 254) chk("count_at_sat", k, viol_count, 8'hFF);
      step(16'hFFFE, 1'b1, 1'b0);
    end
    chk_all(1000, 1'b0, 3'd1, 2'd0, 8'hFF);

    // Async clear while region 0 sits in MID
    step(16'hA000, 1'b1, 1'b0);
    step(16'hA010, 1'b1, 1'b0);
    chk_all(1001, 1'b0, 3'd1, 2'd0, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all(1002, 1'b1, 3'd0, 2'd0, 8'd0);
    #3;
    rst_n = 1'b1;
    step(16'hA000, 1'b1, 1'b0);
    chk_all(1003, 1'b1, 3'd0, 2'd0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
`default_nettype wire
